// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) helpers used by the encrypt and decrypt datapaths.
package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [31:0]  aes_word_t;

   localparam int          AES_NUM_COLS = 4;
   localparam logic [7:0]  AES_POLY     = 8'h1B;

   typedef enum logic [1:0] {IDLE, RUN, DONE} imc_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
   endfunction

   // k is the low nibble of the constant (9, b, d or e); each set bit adds a*2^i.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] k);
      logic [7:0] x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
   endfunction

endpackage

// File: rtl/inv_mix_column_word.sv
// Combinational InvMixColumns on one 32-bit column; byte r=0 sits in the top byte.
module inv_mix_column_word
   import aes_pkg::*;
(
   input  aes_word_t word,
   output aes_word_t mixed
);

   logic [7:0] a0, a1, a2, a3;
   logic [7:0] b0, b1, b2, b3;

   assign a0 = word[31:24];
   assign a1 = word[23:16];
   assign a2 = word[15:8];
   assign a3 = word[7:0];

   assign b0 = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
   assign b1 = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
   assign b2 = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
   assign b3 = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);

   assign mixed = {b0, b1, b2, b3};

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative InvMixColumns: COLS_PER_CYCLE columns per clock, full result with a one-cycle done pulse.
module inv_mix_columns_iter
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       i_start,
   input  aes_state_t i_data,
   output aes_state_t o_data,
   output logic       o_busy,
   output logic       o_done
);

   localparam int NUM_COLS = AES_NUM_COLS;
   localparam int IW       = $clog2(NUM_COLS);
   // One extra bit so the counter reaches NUM_COLS instead of wrapping to 0.
   localparam int CW       = IW + 1;
   localparam logic [CW-1:0] STEP = CW'(COLS_PER_CYCLE);
   localparam logic [CW-1:0] LAST = CW'(NUM_COLS);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
         $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   imc_state_e    state;
   aes_state_t    work;
   logic [CW-1:0] cnt;

   aes_word_t     cols      [NUM_COLS];
   aes_word_t     next_cols [NUM_COLS];
   aes_word_t     mix_in    [COLS_PER_CYCLE];
   aes_word_t     mix_out   [COLS_PER_CYCLE];
   logic [IW-1:0] idx       [COLS_PER_CYCLE];
   aes_state_t    next_work;

   always_comb begin
      for (int c = 0; c < NUM_COLS; c++) cols[c] = work[127-32*c -: 32];
   end

   genvar g;
   generate
      for (g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
         assign idx[g]    = cnt[IW-1:0] + IW'(g);
         assign mix_in[g] = cols[idx[g]];
         inv_mix_column_word u_mix (
            .word  (mix_in[g]),
            .mixed (mix_out[g])
         );
      end
   endgenerate

   always_comb begin
      for (int c = 0; c < NUM_COLS; c++) next_cols[c] = cols[c];
      for (int k = 0; k < COLS_PER_CYCLE; k++) next_cols[idx[k]] = mix_out[k];
      next_work = '0;
      for (int c = 0; c < NUM_COLS; c++) next_work[127-32*c -: 32] = next_cols[c];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state  <= IDLE;
         work   <= '0;
         cnt    <= '0;
         o_data <= '0;
         o_busy <= 1'b0;
         o_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  work   <= i_data;
                  cnt    <= '0;
                  o_busy <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               work <= next_work;
               cnt  <= cnt + STEP;
               // Publish the last group straight from the combinational path so o_data never shows a partial state.
               if (cnt + STEP == LAST) begin
                  o_data <= next_work;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               o_done <= 1'b0;
               if (i_start) begin
                  work   <= i_data;
                  cnt    <= '0;
                  o_busy <= 1'b1;
                  state  <= RUN;
               end else begin
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Directed bench for inv_mix_columns_iter with one instance each for COLS_PER_CYCLE = 1, 2, 4.
module tb_inv_mix_columns_iter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              n_rst;
   logic [2:0]        start;
   logic [127:0]      din;
   logic [2:0][127:0] dout;
   logic [2:0]        busy;
   logic [2:0]        done;

   int total  = 0;
   int passed = 0;

   typedef struct {
      logic [127:0] d;
      logic [127:0] e;
   } vec_t;
   vec_t vecs[6];

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         inv_mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) dut (
            .clk     (clk),
            .n_rst   (n_rst),
            .i_start (start[g]),
            .i_data  (din),
            .o_data  (dout[g]),
            .o_busy  (busy[g]),
            .o_done  (done[g])
         );
      end
   endgenerate

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One transaction on unit u; din is scrambled right after capture to show it is not re-sampled.
   task automatic run_vec(input int u, input logic [127:0] d, input logic [127:0] e, input string tag);
      int n, nb;
      logic moved;
      logic [127:0] prev;
      @(negedge clk);
      din = d;
      start[u] = 1'b1;
      prev = dout[u];
      @(negedge clk);
      start[u] = 1'b0;
      din = ~d;
      n = 1; nb = 0; moved = 1'b0;
      while (!done[u] && n < 40) begin
         if (busy[u]) nb++;
         if (dout[u] !== prev) moved = 1'b1;
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, 128'(n), 128'((4 >> u) + 1));
      chk({tag, " busy cycles"}, 128'(nb), 128'(4 >> u));
      chk({tag, " data stable in run"}, 128'(moved), 128'(0));
      chk({tag, " busy at done"}, 128'(busy[u]), 128'(0));
      chk({tag, " result"}, dout[u], e);
      @(negedge clk);
      chk({tag, " done one cycle"}, 128'(done[u]), 128'(0));
      chk({tag, " result held"}, dout[u], e);
   endtask

   initial begin
      int cnt_done, gap, n;

      vecs[0] = '{128'h046681e5e0cb199a48f8d37a2806264c, 128'hd4bf5d30e0b452aeb84111f11e2798e5};
      vecs[1] = '{128'h8e4da1bc9fdc589d4d7ebdf8c6c6c6c6, 128'hdb135345f20a225c2d26314cc6c6c6c6};
      vecs[2] = '{128'h01010101010101010101010101010101, 128'h01010101010101010101010101010101};
      vecs[3] = '{128'h0, 128'h0};
      vecs[4] = '{128'h9fdc589d8e4da1bcc6c6c6c64d7ebdf8, 128'hf20a225cdb135345c6c6c6c62d26314c};
      vecs[5] = '{128'h01010101c6c6c6c68e4da1bc4d7ebdf8, 128'h01010101c6c6c6c6db1353452d26314c};

      // Reset held with start asserted: nothing may be captured or shown.
      n_rst = 1'b0;
      start = 3'b111;
      din   = vecs[0].d;
      repeat (3) begin
         @(negedge clk);
         for (int u = 0; u < 3; u++) begin
            chk($sformatf("reset data u%0d", u), dout[u], 128'h0);
            chk($sformatf("reset busy/done u%0d", u), 128'({busy[u], done[u]}), 128'h0);
         end
      end
      start = 3'b000;
      @(negedge clk);
      n_rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("no capture after reset", 128'({busy, done}), 128'h0);

      for (int u = 0; u < 3; u++)
         for (int i = 0; i < 6; i++)
            run_vec(u, vecs[i].d, vecs[i].e, $sformatf("cpc%0d v%0d", 1 << u, i));

      // Second start two cycles into a run is dropped.
      @(negedge clk);
      din = vecs[0].d; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      @(negedge clk);
      din = vecs[1].d; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      cnt_done = 0;
      repeat (12) begin
         if (done[0]) cnt_done++;
         @(negedge clk);
      end
      chk("busy-start done count", 128'(cnt_done), 128'd1);
      chk("busy-start result", dout[0], vecs[0].e);
      chk("busy-start not queued", 128'(busy[0]), 128'd0);

      // Start held through DONE: back-to-back runs 5 cycles apart.
      @(negedge clk);
      din = vecs[0].d; start[0] = 1'b1;
      @(negedge clk);
      din = vecs[4].d;
      n = 1;
      while (!done[0] && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("b2b first latency", 128'(n), 128'd5);
      chk("b2b first result", dout[0], vecs[0].e);
      din = vecs[1].d;
      @(negedge clk);
      start[0] = 1'b0;
      chk("b2b recaptured busy", 128'(busy[0]), 128'd1);
      gap = 1;
      while (!done[0] && gap < 40) begin
         @(negedge clk);
         gap++;
      end
      chk("b2b done spacing", 128'(gap), 128'd5);
      chk("b2b second result", dout[0], vecs[1].e);
      @(negedge clk);

      // Reset two cycles into a run aborts it with no done pulse.
      @(negedge clk);
      din = vecs[0].d; start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      for (int u = 0; u < 3; u++)
         chk($sformatf("abort data u%0d", u), dout[u], 128'h0);
      chk("abort busy/done", 128'({busy, done}), 128'h0);
      cnt_done = 0;
      repeat (3) begin
         @(negedge clk);
         if (done != 3'b000) cnt_done++;
      end
      n_rst = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (done != 3'b000) cnt_done++;
      end
      chk("abort no done", 128'(cnt_done), 128'd0);
      run_vec(0, vecs[1].d, vecs[1].e, "post-abort cpc1");
      run_vec(2, vecs[0].d, vecs[0].e, "post-abort cpc4");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
